// File: rtl/seq_div16.sv
// rtl/seq_div16.sv - iterative unsigned 16-bit restoring divider with start/busy/done handshake

module adder_sub (
    input  logic [15:0] op1,
    input  logic [15:0] op2,
    input  logic        sub,
    output logic [15:0] result,
    output logic        carry_out
);
    logic [16:0] op2_ext;
    logic [16:0] total;

    always_comb begin
        op2_ext = {1'b0, op2 ^ {16{sub}}};
        total   = {1'b0, op1} + op2_ext + {16'd0, sub};
    end

    assign result    = total[15:0];
    assign carry_out = total[16];
endmodule

module seq_div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] d_reg;
    // A failed trial only keeps R' when R'[16]=0, so the stored remainder never needs bit 16.
    logic [WIDTH-1:0] r;
    logic [3:0]       count;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] diff;
    logic             carry;
    logic             sub_ok;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] dq_next;

    adder_sub u_sub (
        .op1       (r_shift[WIDTH-1:0]),
        .op2       (d_reg),
        .sub       (1'b1),
        .result    (diff),
        .carry_out (carry)
    );

    always_comb begin
        r_shift = {r, dq[WIDTH-1]};
        sub_ok  = r_shift[WIDTH] | carry;
        r_next  = sub_ok ? diff : r_shift[WIDTH-1:0];
        dq_next = {dq[WIDTH-2:0], sub_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            count       <= 4'd0;
            dq          <= '0;
            d_reg       <= '0;
            r           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dq    <= dividend;
                            d_reg <= divisor;
                            r     <= '0;
                            count <= 4'd0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r     <= r_next;
                    dq    <= dq_next;
                    count <= count + 4'd1;
                    if (count == 4'd15) begin
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= dq_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div16.sv
// tb/tb_seq_div16.sv - randomized and directed self-checking bench for seq_div16

module tb_seq_div16;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    seq_div16 #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference timeline: the period after accepting edge e is numbered e.
    int          cyc     = 0;
    int          free_at = 0;
    bit          op_valid = 1'b0;
    bit          op_dbz   = 1'b0;
    int          op_e     = 0;
    logic [15:0] op_q = '0, op_r = '0;
    logic [15:0] res_q = '0, res_r = '0;
    bit          res_dbz = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            op_valid = 1'b0;
            free_at  = 0;
            res_q    = '0;
            res_r    = '0;
            res_dbz  = 1'b0;
        end else begin
            if (op_valid && !op_dbz && cyc == op_e + 16) begin
                res_q   = op_q;
                res_r   = op_r;
                res_dbz = 1'b0;
            end
            if (start && cyc >= free_at) begin
                op_valid = 1'b1;
                op_e     = cyc;
                op_dbz   = (divisor == 16'd0);
                if (op_dbz) begin
                    op_q    = 16'hFFFF;
                    op_r    = dividend;
                    res_q   = op_q;
                    res_r   = op_r;
                    res_dbz = 1'b1;
                    free_at = cyc + 2;
                end else begin
                    op_q    = dividend / divisor;
                    op_r    = dividend % divisor;
                    free_at = cyc + 18;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            logic exp_busy, exp_done;
            exp_busy = op_valid && !op_dbz && cyc >= op_e && cyc <= op_e + 15;
            exp_done = op_valid && cyc == op_e + (op_dbz ? 0 : 16);
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("done", {31'd0, done}, {31'd0, exp_done});
            check("quotient", {16'd0, quotient}, {16'd0, res_q});
            check("remainder", {16'd0, remainder}, {16'd0, res_r});
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, res_dbz});
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
            lat++;
            if (busy === 1'b1) nbusy++;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_result(input string name, input logic [15:0] q, input logic [15:0] r,
                                 input logic dbz);
        check({name, "_q"}, {16'd0, quotient}, {16'd0, q});
        check({name, "_r"}, {16'd0, remainder}, {16'd0, r});
        check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, dbz});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb;
        logic [15:0] a, b;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(posedge clk); #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        issue(16'd100, 16'd7);
        wait_done(lat, nb);
        check("latency_100_7", lat + 1, 17);
        check("busy_cycles_100_7", nb, 16);
        expect_result("div_100_7", 16'd14, 16'd2, 1'b0);

        issue(16'hFFFF, 16'h8001);
        wait_done(lat, nb);
        expect_result("div_ffff_8001", 16'd1, 16'h7FFE, 1'b0);

        issue(16'hFFFF, 16'hFFFF);
        wait_done(lat, nb);
        expect_result("div_ffff_ffff", 16'd1, 16'd0, 1'b0);

        issue(16'd5, 16'd0);
        wait_done(lat, nb);
        check("latency_dbz", lat + 1, 1);
        check("busy_cycles_dbz", nb, 0);
        expect_result("div_5_0", 16'hFFFF, 16'd5, 1'b1);

        issue(16'd9, 16'd3);
        wait_done(lat, nb);
        expect_result("div_9_3", 16'd3, 16'd0, 1'b0);

        issue(16'd3, 16'd10);
        wait_done(lat, nb);
        expect_result("div_3_10", 16'd0, 16'd3, 1'b0);

        issue(16'hFFFF, 16'd1);
        wait_done(lat, nb);
        expect_result("div_ffff_1", 16'hFFFF, 16'd0, 1'b0);

        issue(16'd1000, 16'd9);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, nb);
        expect_result("div_1000_9", 16'd111, 16'd1, 1'b0);

        issue(16'd200, 16'd3);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        expect_result("abort", 16'd0, 16'd0, 1'b0);
        repeat (20) @(posedge clk);
        issue(16'd200, 16'd3);
        wait_done(lat, nb);
        expect_result("div_200_3", 16'd66, 16'd2, 1'b0);

        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; dividend = 16'd7; divisor = 16'd0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_wins_done", {31'd0, done}, 32'd0);
        expect_result("rst_wins", 16'd0, 16'd0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            int sel;
            a   = 16'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 15));
                2:       b = 16'($urandom_range(16'h8000, 16'hFFFF));
                default: b = 16'($urandom);
            endcase
            issue(a, b);
            wait_done(lat, nb);
            if (b == 16'd0) expect_result("rand_dbz", 16'hFFFF, a, 1'b1);
            else            expect_result("rand", a / b, a % b, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_div16.md
Name: seq_div16

Overview:
Iterative unsigned 16-bit restoring divider for the ALU datapath. It produces one quotient bit per clock and performs each trial subtraction with an adder_sub instance in subtract mode (sub=1). It uses a start/busy/done handshake, so the ALU sequencer can issue DIV/MOD operations that take multiple cycles.

Parameters:
WIDTH, 16, operand/result width; only 16 is supported (adder_sub is fixed 16-bit).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
dividend  input  16  unsigned dividend; captured when start accepted.
divisor  input  16  unsigned divisor; captured when start accepted.
busy  output  1  high while iterating (RUN state).
done  output  1  one-cycle pulse; results valid from this cycle.
quotient  output  16  registered quotient.
remainder  output  16  registered remainder.
div_by_zero  output  1  registered flag for the last completed operation.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- States and transitions:
  - IDLE -> RUN: start=1 and captured divisor!=0. Latch dividend into the shift register, divisor into its register, partial remainder R(17b)=0, count=0.
  - IDLE -> DONE: start=1 and divisor==0. No iteration.
  - RUN: each cycle, R' = {R[15:0], dq[15]}. The dividend/quotient shift register dq shifts left by 1.
    - adder_sub computes diff = R'[15:0] - D (op1=R'[15:0], op2=D, sub=1).
    - Subtract succeeds if R'[16]=1 OR carry_out=1. On success: R=diff (zero-extended), dq[0]=1. On failure: R=R', dq[0]=0.
    - count increments; after the 16th iteration (count==15), go to DONE.
  - DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
- Result registers:
  - Normal completion: quotient=dq and remainder=R[15:0], written on the edge entering DONE; div_by_zero=0.
  - Divide by zero: quotient=16'hFFFF, remainder=captured dividend, div_by_zero=1.
  - quotient, remainder and div_by_zero hold until the next completion or reset; they do not change while busy.
- Latency, with start sampled high at edge k:
  - Normal: busy=1 for cycles k+1..k+16; done=1 in cycle k+17.
  - Divide by zero: busy never asserts; done=1 in cycle k+1.
- Handshake rules:
  - start is ignored in RUN and DONE; no queueing.
  - Operands may change freely after acceptance.
  - Back-to-back: start may be reasserted in the IDLE cycle after done. Minimum issue interval is 18 cycles normal, 2 for divide by zero.
- Boundaries:
  - Dividend < divisor: quotient=0, remainder=dividend.
  - Divisor=1: quotient=dividend, remainder=0.
  - R'[16]=1 (divisor >= 0x8000): subtract always succeeds. The 16-bit diff is exact because the true remainder < divisor fits in 16 bits.
  - rst asserted mid-RUN: next edge returns to the reset state. The operation is abandoned, done is not pulsed, and the results are cleared to 0.
  - rst and start high in the same cycle: rst wins.

Test Plan:
- Reset, then start with dividend=100, divisor=7 -> busy high for 16 cycles; done pulses exactly 17 cycles after start; quotient=14, remainder=2, div_by_zero=0.
- dividend=16'hFFFF, divisor=16'h8001 -> quotient=1, remainder=16'h7FFE (exercises the R'[16] path). Also dividend=16'hFFFF, divisor=16'hFFFF -> quotient=1, remainder=0.
- dividend=5, divisor=0 -> done the cycle after start; busy stays 0; quotient=16'hFFFF, remainder=5, div_by_zero=1. Follow with 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- dividend=3, divisor=10 -> quotient=0, remainder=3. Dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0.
- Start 1000/9, pulse start again with 50/5 at busy cycle 4 -> second request ignored; result quotient=111, remainder=1; outputs stable while busy.
- Start 200/3, assert rst at busy cycle 8 -> next cycle busy=0, done never pulses, quotient=remainder=0. A new start of 200/3 then yields quotient=66, remainder=2.
- Randomized: 1000 random pairs (including divisor=0) checked against the reference model q=a/b, r=a%b.
